// File: rtl/trisc_core.sv
// trisc_core: single-accumulator CPU driven by an internal microsequencer.
//
// Parameters
//   W        address width = data width; instruction word is {opcode[3:0], operand[W-1:0]}
//   PC_RESET program counter value after reset
//
// Ports
//   clock      in   rising-edge system clock
//   clear      in   asynchronous active-low reset
//   run        in   1 = execute, 0 = stop after the current instruction
//   mem_addr   out  RAM address
//   mem_rd     out  read strobe, data arrives on mem_rdata one cycle later
//   mem_wr     out  write strobe, RAM stores mem_wdata at mem_addr on this edge
//   mem_wdata  out  {4'b0, acc}
//   mem_rdata  in   RAM read data (upper 4 bits used only as opcode)
//   pc, acc    out  program counter and accumulator
//   ir         out  current opcode
//   zf, cf     out  zero and carry flags
//   halted     out  high in HALT
//   busy       out  high in any state other than IDLE or HALT
//
// Optional feature: define TRISC_CALL_EN to add a one-deep return register with
// CALL (opcode B) and RET (opcode C). Without it both opcodes execute as NOP.
//
// Memory strobes, address and status outputs are registered: they are computed
// from the next state so that they are valid for the whole cycle of the state
// that uses them, and an asynchronous reset drops them immediately.

module trisc_core #(
  parameter int              W        = 8,
  parameter logic [W-1:0]    PC_RESET = {W{1'b0}}
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           run,
  output logic [W-1:0]   mem_addr,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [W+3:0]   mem_wdata,
  input  logic [W+3:0]   mem_rdata,
  output logic [W-1:0]   pc,
  output logic [W-1:0]   acc,
  output logic [3:0]     ir,
  output logic           zf,
  output logic           cf,
  output logic           halted,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_INC  = 4'h6;
  localparam logic [3:0] OP_CLR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W:0]   ONE_W1 = {{W{1'b0}}, 1'b1};

  // Opcodes that need a second (MEM) cycle to consume a data read.
  function automatic logic is_mem_read(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  state_t         r_state, w_state_nx;
  logic [W-1:0]   r_pc, w_pc_nx;
  logic [W-1:0]   r_acc, w_acc_nx;
  logic [3:0]     r_ir, w_ir_nx;
  logic [W-1:0]   r_opnd, w_opnd_nx;
  logic           r_zf, w_zf_nx;
  logic           r_cf, w_cf_nx;
  logic           r_run_d;
  logic [W-1:0]   r_mem_addr, w_mem_addr_nx;
  logic           r_mem_rd, w_mem_rd_nx;
  logic           r_mem_wr, w_mem_wr_nx;
  logic           r_halted, w_halted_nx;
  logic           r_busy, w_busy_nx;
  logic           w_cont;
  logic [W-1:0]   w_d;
  logic [W:0]     w_sum, w_diff, w_inc;
`ifdef TRISC_CALL_EN
  logic [W-1:0]   r_ret, w_ret_nx;
`endif

  assign w_d    = mem_rdata[W-1:0];
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_d};
  // Top bit of the W+1 bit difference is the borrow.
  assign w_diff = {1'b0, r_acc} - {1'b0, w_d};
  assign w_inc  = {1'b0, r_acc} + ONE_W1;
  assign w_cont = run;

  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = {4'b0000, r_acc};
  assign pc        = r_pc;
  assign acc       = r_acc;
  assign ir        = r_ir;
  assign zf        = r_zf;
  assign cf        = r_cf;
  assign halted    = r_halted;
  assign busy      = r_busy;

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; HALT is left only on a 0->1 edge of run.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   w_state_nx = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_state_nx = S_DECODE;
      S_DECODE: w_state_nx = S_EXEC;
      S_EXEC: begin
        if (is_mem_read(r_ir)) begin
          w_state_nx = S_MEM;
        end else if (r_ir == OP_HLT) begin
          w_state_nx = S_HALT;
        end else begin
          w_state_nx = w_cont ? S_FETCH : S_IDLE;
        end
      end
      S_MEM:    w_state_nx = w_cont ? S_FETCH : S_IDLE;
      S_HALT:   w_state_nx = (run && !r_run_d) ? S_FETCH : S_HALT;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Output logic, decoded from the state being entered so it can be registered.
  always_comb begin
    w_mem_rd_nx   = 1'b0;
    w_mem_wr_nx   = 1'b0;
    w_mem_addr_nx = r_mem_addr;
    w_halted_nx   = 1'b0;
    w_busy_nx     = 1'b1;
    case (w_state_nx)
      S_FETCH: begin
        w_mem_rd_nx   = 1'b1;
        w_mem_addr_nx = w_pc_nx;
      end
      S_EXEC: begin
        if (is_mem_read(w_ir_nx)) begin
          w_mem_rd_nx   = 1'b1;
          w_mem_addr_nx = w_opnd_nx;
        end else if (w_ir_nx == OP_STA) begin
          w_mem_wr_nx   = 1'b1;
          w_mem_addr_nx = w_opnd_nx;
        end else begin
          w_mem_addr_nx = r_mem_addr;
        end
      end
      S_DECODE, S_MEM: begin
        w_busy_nx = 1'b1;
      end
      S_HALT: begin
        w_halted_nx = 1'b1;
        w_busy_nx   = 1'b0;
      end
      default: begin
        w_busy_nx = 1'b0;
      end
    endcase
  end

  // Datapath next values for PC, IR, operand, ACC and flags.
  always_comb begin
    w_pc_nx   = r_pc;
    w_acc_nx  = r_acc;
    w_ir_nx   = r_ir;
    w_opnd_nx = r_opnd;
    w_zf_nx   = r_zf;
    w_cf_nx   = r_cf;
`ifdef TRISC_CALL_EN
    w_ret_nx  = r_ret;
`endif
    case (r_state)
      S_DECODE: begin
        w_ir_nx   = mem_rdata[W+3:W];
        w_opnd_nx = mem_rdata[W-1:0];
        w_pc_nx   = r_pc + ONE_W1[W-1:0];
      end
      S_EXEC: begin
        case (r_ir)
          OP_INC: begin
            w_acc_nx = w_inc[W-1:0];
            w_cf_nx  = w_inc[W];
            w_zf_nx  = (w_inc[W-1:0] == ZERO_W);
          end
          OP_CLR: begin
            w_acc_nx = ZERO_W;
            w_zf_nx  = 1'b1;
            w_cf_nx  = 1'b0;
          end
          OP_JMP: w_pc_nx = r_opnd;
          OP_JZ:  w_pc_nx = r_zf ? r_opnd : r_pc;
          OP_JC:  w_pc_nx = r_cf ? r_opnd : r_pc;
`ifdef TRISC_CALL_EN
          OP_CALL: begin
            // pc already points past the CALL.
            w_ret_nx = r_pc;
            w_pc_nx  = r_opnd;
          end
          OP_RET:  w_pc_nx = r_ret;
`else
          OP_CALL, OP_RET: begin
            w_pc_nx = r_pc;
          end
`endif
          default: w_pc_nx = r_pc;
        endcase
      end
      S_MEM: begin
        case (r_ir)
          OP_LDA: begin
            w_acc_nx = w_d;
            w_zf_nx  = (w_d == ZERO_W);
          end
          OP_ADD: begin
            w_acc_nx = w_sum[W-1:0];
            w_cf_nx  = w_sum[W];
            w_zf_nx  = (w_sum[W-1:0] == ZERO_W);
          end
          OP_SUB: begin
            w_acc_nx = w_diff[W-1:0];
            w_cf_nx  = ~w_diff[W];
            w_zf_nx  = (w_diff[W-1:0] == ZERO_W);
          end
          OP_AND: begin
            w_acc_nx = r_acc & w_d;
            w_zf_nx  = ((r_acc & w_d) == ZERO_W);
          end
          default: w_acc_nx = r_acc;
        endcase
      end
      default: w_pc_nx = r_pc;
    endcase
  end

  // Architectural registers and the run edge detector.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_pc    <= PC_RESET;
      r_acc   <= ZERO_W;
      r_ir    <= OP_NOP;
      r_opnd  <= ZERO_W;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
      r_run_d <= 1'b0;
    end else begin
      r_pc    <= w_pc_nx;
      r_acc   <= w_acc_nx;
      r_ir    <= w_ir_nx;
      r_opnd  <= w_opnd_nx;
      r_zf    <= w_zf_nx;
      r_cf    <= w_cf_nx;
      r_run_d <= run;
    end
  end

`ifdef TRISC_CALL_EN
  // One-deep return address; a nested CALL overwrites it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_ret <= ZERO_W;
    end else begin
      r_ret <= w_ret_nx;
    end
  end
`endif

  // Registered memory strobes and status outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_mem_addr <= ZERO_W;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_halted   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mem_addr <= w_mem_addr_nx;
      r_mem_rd   <= w_mem_rd_nx;
      r_mem_wr   <= w_mem_wr_nx;
      r_halted   <= w_halted_nx;
      r_busy     <= w_busy_nx;
    end
  end

endmodule
